move_sched: RTL
===============

MOVE_SCHED -- requirements
Module: move_sched

Interface
REQ-001 Parameter GRAV_PERIOD, default 16'd1000, base gravity interval in clka cycles; legal range 8..65535.
REQ-002 clka  input  1  sole clock; all state updates on posedge clka.
REQ-003 restart_n  input  1  reset, synchronous, active-low.
REQ-004 start_move  input  1  level from main FSM; high while game is in MOVE state.
REQ-005 level  input  2  speed level; gravity period = GRAV_PERIOD >> level.
REQ-006 btn_left, btn_right, btn_rot, btn_drop  input  1 each  debounced single-cycle request pulses.
REQ-007 chk_ack  input  1  collision checker done, one-cycle pulse.
REQ-008 chk_ok  input  1  checker result, valid only when chk_ack=1; 1 = move legal.
REQ-009 chk_req  output  1  request to collision checker.
REQ-010 chk_op  output  2  move under test: 00 DOWN, 01 LEFT, 10 RIGHT, 11 ROT.
REQ-011 commit  output  1  one-cycle pulse; piece registers apply chk_op.
REQ-012 touched  output  1  one-cycle pulse to main FSM; piece has landed.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, SELECT, CHECK, COMMIT, TOUCH, DONE.
REQ-015 IDLE -> SELECT when start_move=1; in any state except CHECK, start_move=0 SHALL force IDLE next cycle.
REQ-016 Pending flags grav_p, rot_p, left_p, right_p, drop_p SHALL set on the corresponding event while start_move=1 and clear when serviced or when start_move=0.
REQ-017 btn_left and btn_right in the same cycle SHALL set neither flag; a pulse for an already-set flag SHALL be ignored (no queueing beyond one).
REQ-018 Gravity counter (16 bits) SHALL count while start_move=1 and drop_p=0, SHALL clear to 0 whenever start_move=0, and on reaching (GRAV_PERIOD>>level)-1 SHALL wrap to 0 and set grav_p.
REQ-019 SELECT priority: drop_p or grav_p (op DOWN) > rot_p (ROT) > left_p (LEFT) > right_p (RIGHT); no flag set -> stay in SELECT.
REQ-020 SELECT with a flag set -> CHECK next cycle; chk_op SHALL be latched on entry to CHECK and held stable through CHECK.
REQ-021 chk_req SHALL be 1 in every CHECK cycle and 0 in every other state.
REQ-022 CHECK SHALL hold until chk_ack=1 even if start_move falls; on ack with start_move=0 -> IDLE, no commit, no touched.
REQ-023 On ack with chk_ok=1 -> COMMIT: commit=1 for exactly one cycle with chk_op unchanged; serviced flag cleared (drop_p excepted); -> SELECT.
REQ-024 On ack with chk_ok=0 and op LEFT/RIGHT/ROT: flag cleared, no commit, -> SELECT.
REQ-025 On ack with chk_ok=0 and op DOWN: grav_p and drop_p cleared -> TOUCH: touched=1 one cycle -> DONE.
REQ-026 Hard drop: while drop_p=1, SELECT SHALL issue DOWN repeatedly (commit each success) until a DOWN fails; other flags remain pending but are cleared by REQ-016 on MOVE exit.
REQ-027 A grav_p set during a drop_p DOWN sequence SHALL be absorbed (cleared together with drop_p).
REQ-028 DONE: all outputs except busy 0; btn pulses ignored; exit to IDLE only when start_move=0.
REQ-029 Minimum turnaround: event at cycle N -> chk_req at N+2 (flag N+1, SELECT N+1, CHECK N+2).

Reset
REQ-030 restart_n=0 at a posedge SHALL force IDLE, clear all flags and gravity counter, and drive chk_req, chk_op, commit, touched, busy to 0 at the next cycle, overriding any state including mid-CHECK.
REQ-031 After restart_n returns to 1, the block SHALL ignore any chk_ack from an abandoned handshake while not in CHECK.

Verification
REQ-032 restart_n=0 during CHECK with chk_req=1 -> next cycle all outputs 0, state IDLE; late chk_ack causes no commit.
REQ-033 GRAV_PERIOD=8, level=0, start_move=1, checker acks ok 1 cycle after req -> chk_req op 00 first at cycle 9 after start_move, commit pulse 2 cycles later, repeats every 8 cycles.
REQ-034 btn_rot pulse in the same cycle grav_p sets -> DOWN checked/committed first, then ROT (op 11) checked next.
REQ-035 DOWN acked with chk_ok=0 -> touched=1 exactly one cycle, commit stays 0, busy=1 until start_move=0, then IDLE.
REQ-036 btn_drop, checker returns ok,ok,ok,fail on DOWN -> exactly 3 commit pulses with op 00, then one touched pulse; no gravity request interleaved.
REQ-037 btn_left and btn_right same cycle -> no chk_req issued; btn_left alone 1 cycle later -> op 01 request.

Source files
------------

// File: rtl/move_sched.sv
// move_sched: arbitrates gravity and player moves through the collision checker, one move at a time
module move_sched #(
    parameter logic [15:0] GRAV_PERIOD = 16'd1000
) (
    input  logic       clka,
    input  logic       restart_n,
    input  logic       start_move,
    input  logic [1:0] level,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_drop,
    input  logic       chk_ack,
    input  logic       chk_ok,
    output logic       chk_req,
    output logic [1:0] chk_op,
    output logic       commit,
    output logic       touched,
    output logic       busy
);
    localparam logic [2:0] IDLE = 3'd0, SELECT = 3'd1, CHECK = 3'd2, COMMIT = 3'd3, TOUCH = 3'd4, DONE = 3'd5;
    localparam logic [1:0] OP_DOWN = 2'b00, OP_LEFT = 2'b01, OP_RIGHT = 2'b10, OP_ROT = 2'b11;

    logic [2:0]  state, state_n;
    logic [1:0]  op, op_sel;
    logic [15:0] grav_cnt, grav_lim;
    logic        grav_p, rot_p, left_p, right_p, drop_p;
    logic        grav_hit, any_p, btn_en, resolve, clr_down, clr_drop;

    assign grav_lim = (GRAV_PERIOD >> level) - 16'd1;
    assign grav_hit = start_move && !drop_p && grav_cnt >= grav_lim;
    assign any_p    = grav_p | rot_p | left_p | right_p | drop_p;
    assign op_sel   = (grav_p | drop_p) ? OP_DOWN : rot_p ? OP_ROT : left_p ? OP_LEFT : OP_RIGHT;
    assign btn_en   = start_move && state != DONE;
    assign resolve  = state == CHECK && chk_ack && start_move;
    // any resolved DOWN also absorbs a gravity tick that arrived during a hard drop
    assign clr_down = resolve && op == OP_DOWN;
    assign clr_drop = clr_down && !chk_ok;

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = start_move ? SELECT : IDLE;
            SELECT:  state_n = !start_move ? IDLE : any_p ? CHECK : SELECT;
            CHECK:   state_n = !chk_ack ? CHECK : !start_move ? IDLE : chk_ok ? COMMIT : op == OP_DOWN ? TOUCH : SELECT;
            COMMIT:  state_n = start_move ? SELECT : IDLE;
            TOUCH:   state_n = start_move ? DONE : IDLE;
            DONE:    state_n = start_move ? DONE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            state    <= IDLE;
            op       <= OP_DOWN;
            grav_cnt <= '0;
            grav_p   <= 1'b0;
            rot_p    <= 1'b0;
            left_p   <= 1'b0;
            right_p  <= 1'b0;
            drop_p   <= 1'b0;
        end else begin
            state    <= state_n;
            op       <= (state == SELECT) ? op_sel : op;
            grav_cnt <= (!start_move || grav_hit) ? 16'd0 : drop_p ? grav_cnt : grav_cnt + 16'd1;
            grav_p   <= start_move && ((grav_p && !clr_down) || grav_hit);
            drop_p   <= start_move && ((drop_p && !clr_drop) || (btn_en && btn_drop));
            rot_p    <= start_move && ((rot_p && !(resolve && op == OP_ROT)) || (btn_en && btn_rot));
            left_p   <= start_move && ((left_p && !(resolve && op == OP_LEFT)) || (btn_en && btn_left && !btn_right));
            right_p  <= start_move && ((right_p && !(resolve && op == OP_RIGHT)) || (btn_en && btn_right && !btn_left));
        end
    end

    assign chk_req = state == CHECK;
    assign chk_op  = (state == CHECK || state == COMMIT) ? op : OP_DOWN;
    assign commit  = state == COMMIT;
    assign touched = state == TOUCH;
    assign busy    = state != IDLE;
endmodule
